// File: rtl/gelu_vec_top.sv
// Multi-lane streaming i-GELU: five-stage stallable pipeline with per-layer ROM constants and frame tracking.
// Define GELU_SAT_EN to saturate the narrowed result; per-layer constants are packed parameter images QB_ROM/QC_ROM/Q1_ROM.

module gelu_lane #(
    parameter int D_W_ACC = 32,
    parameter int SHIFT   = 14
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld0,
    input  logic                      en,
    input  logic signed [D_W_ACC-1:0] q_in,
    input  logic signed [D_W_ACC-1:0] qb0,
    input  logic signed [D_W_ACC-1:0] qc1,
    input  logic signed [D_W_ACC-1:0] q1c2,
    output logic signed [D_W_ACC-1:0] y
);
    localparam int D  = D_W_ACC;
    localparam int AW = D + 1;
    localparam int LW = 2*D + 1;
    localparam int SW = 2*D + 2;
    localparam int PW = 3*D + 2;

    logic signed [D-1:0]  q0, qs1, qs2;
    logic signed [AW-1:0] a1;
    logic signed [LW-1:0] ql2;
    logic signed [PW-1:0] p3;

    logic signed [AW-1:0] qx, abs_q, lim, a_n;
    logic signed [LW-1:0] l_n, ql_n;
    logic signed [PW-1:0] p_n;
    logic signed [D-1:0]  y_n;
`ifdef GELU_SAT_EN
    logic signed [PW-1:0] sh;
`endif

    always_comb begin
        qx    = AW'(q0);
        abs_q = qx[AW-1] ? -qx : qx;
        lim   = -AW'(qb0);
        // a lands in [qb, 0]: clip |q| to -qb, then offset by qb
        a_n   = ((abs_q < lim) ? abs_q : lim) + AW'(qb0);
        l_n   = LW'(a1) * LW'(a1) + LW'(qc1);
        ql_n  = qs1[D-1] ? -l_n : l_n;
        p_n   = PW'(qs2) * PW'(SW'(ql2) + SW'(q1c2));
`ifdef GELU_SAT_EN
        sh = p3 >>> SHIFT;
        if (&sh[PW-1:D-1] | ~|sh[PW-1:D-1])
            y_n = sh[D-1:0];
        else
            y_n = sh[PW-1] ? {1'b1, {(D-1){1'b0}}} : {1'b0, {(D-1){1'b1}}};
`else
        y_n = D'(p3 >>> SHIFT);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0  <= '0;
            qs1 <= '0;
            qs2 <= '0;
            a1  <= '0;
            ql2 <= '0;
            p3  <= '0;
            y   <= '0;
        end else begin
            if (ld0) q0 <= q_in;
            if (en) begin
                qs1 <= q0;
                a1  <= a_n;
                qs2 <= qs1;
                ql2 <= ql_n;
                p3  <= p_n;
                y   <= y_n;
            end
        end
    end
endmodule

module gelu_vec_top #(
    parameter int LANES        = 4,
    parameter int D_W_ACC      = 32,
    parameter int SHIFT        = 14,
    parameter int MATRIXSIZE_W = 16,
    parameter int LAYERS       = 12,
    parameter int BATCHES      = 1,
    parameter logic [LAYERS*D_W_ACC-1:0] QB_ROM = {LAYERS{D_W_ACC'(-100)}},
    parameter logic [LAYERS*D_W_ACC-1:0] QC_ROM = {LAYERS{D_W_ACC'(-20000)}},
    parameter logic [LAYERS*D_W_ACC-1:0] Q1_ROM = {LAYERS{D_W_ACC'(30000)}},
    localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [LANES*D_W_ACC-1:0]   qin_tdata,
    input  logic                       qin_tvalid,
    output logic                       qin_tready,
    input  logic                       qin_tlast,
    output logic [LANES*D_W_ACC-1:0]   qout_tdata,
    output logic                       qout_tvalid,
    input  logic                       qout_tready,
    output logic                       qout_tlast,
    input  logic [MATRIXSIZE_W-1:0]    DIM1,
    input  logic [MATRIXSIZE_W-1:0]    DIM2,
    output logic [LW-1:0]              layer_o,
    output logic                       frame_err
);
    localparam int STAGES = 4;
    localparam int MW     = MATRIXSIZE_W;
    localparam int LG     = $clog2(LANES);
    localparam logic [MW-1:0] BATCH_LAST = MW'(BATCHES - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(LAYERS - 1);

    logic [STAGES:0] vld_pipe;
    logic en, ld0, in_fire, out_fire, adv, sw_bub, rom_ok;
    logic [MW-1:0] bpr, col, row, batch, ocol, orow;
    logic col_last, row_last, in_end, ocol_last, orow_last;
    logic [LW-1:0] layer;
    logic signed [D_W_ACC-1:0] rom_qb, rom_qc, rom_q1;
    logic signed [D_W_ACC-1:0] k_qb0, k_qc0, k_qc1, k_q10, k_q11, k_q12;
    logic [LANES-1:0][D_W_ACC-1:0] y_l;

    assign en          = qout_tready | ~vld_pipe[STAGES];
    assign ld0         = en | ~vld_pipe[0];
    assign qin_tready  = rom_ok & ~sw_bub & ld0;
    assign in_fire     = qin_tvalid & qin_tready;
    assign out_fire    = vld_pipe[STAGES] & qout_tready;
    assign qout_tvalid = vld_pipe[STAGES];
    assign qout_tdata  = y_l;
    assign layer_o     = layer;

    assign bpr       = DIM2 >> LG;
    assign col_last  = (col == bpr - MW'(1));
    assign row_last  = (row == DIM1 - MW'(1));
    assign in_end    = col_last & row_last;
    assign adv       = in_fire & in_end & (batch == BATCH_LAST);
    assign ocol_last = (ocol == bpr - MW'(1));
    assign orow_last = (orow == DIM1 - MW'(1));
    assign qout_tlast = vld_pipe[STAGES] & ocol_last & orow_last;

    // ROM read is registered on the layer index; rom_ok gates the first read after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_ok <= 1'b0;
            rom_qb <= '0;
            rom_qc <= '0;
            rom_q1 <= '0;
        end else begin
            rom_ok <= 1'b1;
            rom_qb <= QB_ROM[int'(layer)*D_W_ACC +: D_W_ACC];
            rom_qc <= QC_ROM[int'(layer)*D_W_ACC +: D_W_ACC];
            rom_q1 <= Q1_ROM[int'(layer)*D_W_ACC +: D_W_ACC];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            k_qb0 <= '0; k_qc0 <= '0; k_qc1 <= '0;
            k_q10 <= '0; k_q11 <= '0; k_q12 <= '0;
        end else begin
            if (ld0) begin
                vld_pipe[0] <= in_fire;
                k_qb0 <= rom_qb;
                k_qc0 <= rom_qc;
                k_q10 <= rom_q1;
            end
            if (en) begin
                vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
                k_qc1 <= k_qc0;
                k_q11 <= k_q10;
                k_q12 <= k_q11;
            end
        end
    end

    // Input-side framing: column/row/batch/layer, plus one-cycle stall after a layer switch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0; row <= '0; batch <= '0; layer <= '0;
            sw_bub <= 1'b0; frame_err <= 1'b0;
        end else begin
            sw_bub <= adv;
            if (in_fire) begin
                if (qin_tlast != in_end) frame_err <= 1'b1;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + MW'(1);
                end else begin
                    col <= col + MW'(1);
                end
                if (in_end) begin
                    if (batch == BATCH_LAST) begin
                        batch <= '0;
                        layer <= (layer == LAYER_LAST) ? '0 : layer + LW'(1);
                    end else begin
                        batch <= batch + MW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ocol <= '0; orow <= '0;
        end else if (out_fire) begin
            if (ocol_last) begin
                ocol <= '0;
                orow <= orow_last ? '0 : orow + MW'(1);
            end else begin
                ocol <= ocol + MW'(1);
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        gelu_lane #(.D_W_ACC(D_W_ACC), .SHIFT(SHIFT)) u_lane (
            .clk  (clk),
            .rst_n(rst_n),
            .ld0  (ld0),
            .en   (en),
            .q_in (qin_tdata[i*D_W_ACC +: D_W_ACC]),
            .qb0  (k_qb0),
            .qc1  (k_qc1),
            .q1c2 (k_q12),
            .y    (y_l[i])
        );
    end
endmodule

// File: tb/tb_gelu_vec_top.sv
// Directed bench for gelu_vec_top: 4 lanes, 3 layers x 2 batches, 2x8 frames (4 beats/frame).
module tb_gelu_vec_top;
    localparam int LANES = 4, D = 32, MW = 16, LAYERS = 3;
    localparam logic [LAYERS*D-1:0] QB_P = {-32'sd50,   -32'sd100,   -32'sd100};
    localparam logic [LAYERS*D-1:0] QC_P = {-32'sd5000, -32'sd20000, -32'sd20000};
    localparam logic [LAYERS*D-1:0] Q1_P = {32'sd10000, 32'sd200000, 32'sd30000};
`ifdef GELU_SAT_EN
    localparam int OVF = 32'h7fffffff;
`else
    localparam int OVF = -1088421888;
`endif

    logic clk = 1'b0, rst_n = 1'b0;
    logic [LANES*D-1:0] qin_tdata, qout_tdata;
    logic qin_tvalid, qin_tready, qin_tlast, qout_tvalid, qout_tready, qout_tlast, frame_err;
    logic [MW-1:0] DIM1 = 16'd2, DIM2 = 16'd8;
    logic [1:0] layer_o;

    always #5 clk = ~clk;

    gelu_vec_top #(.LANES(LANES), .D_W_ACC(D), .SHIFT(14), .MATRIXSIZE_W(MW), .LAYERS(LAYERS),
                   .BATCHES(2), .QB_ROM(QB_P), .QC_ROM(QC_P), .Q1_ROM(Q1_P)) dut (
        .clk(clk), .rst_n(rst_n),
        .qin_tdata(qin_tdata), .qin_tvalid(qin_tvalid), .qin_tready(qin_tready), .qin_tlast(qin_tlast),
        .qout_tdata(qout_tdata), .qout_tvalid(qout_tvalid), .qout_tready(qout_tready), .qout_tlast(qout_tlast),
        .DIM1(DIM1), .DIM2(DIM2), .layer_o(layer_o), .frame_err(frame_err)
    );

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, out_idx = 0, beat_in_frame = 0, frame_cnt = 0;
    int t_first_in = -1, t_first_out = -1;
    bit bub_pend = 0, bub_end_pend = 0, hold_pend = 0;
    logic [127:0] hold_d;
    logic [1:0] hold_c;
    logic [127:0] exp_q[$];

    int kqb[3] = '{-100, -100, -50};
    int kqc[3] = '{-20000, -20000, -5000};
    int kq1[3] = '{30000, 200000, 10000};
    int tab[16] = '{50, -50, 0, -1, 1, 100, -100, 99, -99, 101, -101, 12345, -12345,
                    1073741824, int'(32'h80000000), 32'h7fffffff};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] gref(input int q, input int lay);
        longint aq, lim, a, l, ql, s;
        logic signed [127:0] p, sh;
        aq  = (q < 0) ? -longint'(q) : longint'(q);
        lim = -longint'(kqb[lay]);
        a   = ((aq < lim) ? aq : lim) + kqb[lay];
        l   = a * a + kqc[lay];
        ql  = (q < 0) ? -l : l;
        s   = ql + kq1[lay];
        p   = 128'(q) * 128'(s);
        sh  = p >>> 14;
`ifdef GELU_SAT_EN
        if (sh > 128'sh7fffffff) return 32'h7fffffff;
        if (sh < -128'sh80000000) return 32'h80000000;
`endif
        return sh[31:0];
    endfunction

    function automatic logic [127:0] bref(input logic [127:0] d, input int lay);
        logic [127:0] r;
        for (int l = 0; l < LANES; l++) r[l*32 +: 32] = gref($signed(d[l*32 +: 32]), lay);
        return r;
    endfunction

    function automatic logic [127:0] mk(input int l0, input int l1, input int l2, input int l3);
        return {32'(l3), 32'(l2), 32'(l1), 32'(l0)};
    endfunction

    function automatic logic [127:0] stim(input int n);
        return mk(tab[(n*5) % 16], tab[(n*5+1) % 16], tab[(n*5+2) % 16], tab[(n*5+3) % 16]);
    endfunction

    // One clock cycle: drive at negedge, sample 1ns later, then step to the next negedge
    task automatic cycle(input bit drv, input logic [127:0] d, input bit last, input int rmode,
                         input bit use_h, input logic [127:0] h, output bit fired);
        qout_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ($urandom_range(0, 9) >= 3) : 1'b0;
        qin_tvalid = drv; qin_tdata = d; qin_tlast = last;
        #1;
        if (hold_pend) begin
            chk("hold_data", qout_tdata, hold_d);
            chk("hold_ctl", {qout_tvalid, qout_tlast}, hold_c);
        end
        if (bub_end_pend && qout_tready) chk("bubble_end", qin_tready, 1);
        bub_end_pend = 0;
        if (bub_pend) begin
            chk("bubble", qin_tready, 0);
            bub_pend = 0; bub_end_pend = 1;
        end
        if (qout_tvalid && t_first_out < 0) t_first_out = cyc;
        if (qout_tvalid && qout_tready) begin
            if (exp_q.size() == 0) chk("out_unexpected", exp_q.size(), 1);
            else begin
                chk("out_data", qout_tdata, exp_q.pop_front());
                chk("out_tlast", qout_tlast, (out_idx % 4) == 3);
            end
            out_idx++;
        end
        hold_pend = qout_tvalid && !qout_tready;
        hold_d = qout_tdata;
        hold_c = {qout_tvalid, qout_tlast};
        fired = drv && qin_tready;
        if (fired) begin
            if (t_first_in < 0) t_first_in = cyc;
            if (beat_in_frame == 0) chk("layer_o", layer_o, (frame_cnt / 2) % 3);
            exp_q.push_back(use_h ? h : bref(d, (frame_cnt / 2) % 3));
            beat_in_frame++;
            if (beat_in_frame == 4) begin
                beat_in_frame = 0;
                frame_cnt++;
                if (frame_cnt % 2 == 0) bub_pend = 1;
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [127:0] d, input bit last, input int rmode,
                        input bit use_h, input logic [127:0] h);
        bit f;
        int tries = 0;
        do begin
            cycle(1, d, last, rmode, use_h, h, f);
            tries++;
        end while (!f && tries < 100);
        if (!f) chk("send_timeout", tries, 0);
    endtask

    task automatic idle(input int n, input int rmode);
        bit f;
        for (int i = 0; i < n; i++) cycle(0, '0, 0, rmode, 0, '0, f);
    endtask

    task automatic drain();
        bit f;
        int k = 0;
        while (exp_q.size() > 0 && k < 300) begin
            cycle(0, '0, 0, 0, 0, '0, f);
            k++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit f;
        qin_tvalid = 0; qin_tdata = '0; qin_tlast = 0; qout_tready = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_tvalid", qout_tvalid, 0);
        chk("rst_tdata", qout_tdata, 0);
        chk("rst_tlast", qout_tlast, 0);
        chk("rst_tready", qin_tready, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_layer", layer_o, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("rdy_at_release", qin_tready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("rdy_after_release", qin_tready, 1);

        // Continuous frames 0..1 (layer 0), latency and hand-computed beat
        for (int n = 0; n < 8; n++)
            send((n == 0) ? mk(50, -50, 0, -1) : stim(n), (n % 4) == 3, 0,
                 n == 0, mk(38, -145, 0, -3));
        drain();
        chk("latency", t_first_out - t_first_in, 5);
        chk("ferr_clean", frame_err, 0);

        // 64 beats under random backpressure, frames 2..17 cycling through all layers
        for (int n = 8; n < 72; n++) begin
            if (n == 8)
                send(mk(1073741824, 0, 50, -50), 0, 1, 1, mk(OVF, 0, 556, -664));
            else if (n == 16)
                send(mk(50, -50, 1000, int'(32'h80000000)), 0, 1, 1, mk(15, -46, 305, -1966080000));
            else
                send(stim(n), (n % 4) == 3, 1, 0, '0);
        end
        drain();

        // Framing error: tlast on beat 2 of a 4-beat frame, then a clean frame
        chk("ferr_pre", frame_err, 0);
        send(stim(100), 0, 0, 0, '0);
        send(stim(101), 1, 0, 0, '0);
        chk("ferr_set", frame_err, 1);
        send(stim(102), 0, 0, 0, '0);
        send(stim(103), 0, 0, 0, '0);
        for (int n = 0; n < 4; n++) send(stim(104 + n), n == 3, 0, 0, '0);
        drain();
        chk("ferr_sticky", frame_err, 1);
        chk("layer_pre_rst", layer_o, 1);

        // Reset with beats stalled in flight
        send(stim(110), 0, 2, 0, '0);
        send(stim(111), 0, 2, 0, '0);
        for (int k = 0; k < 20 && !qout_tvalid; k++) cycle(0, '0, 0, 2, 0, '0, f);
        chk("fill", qout_tvalid, 1);
        rst_n = 0;
        #1;
        chk("mid_rst_tvalid", qout_tvalid, 0);
        chk("mid_rst_layer", layer_o, 0);
        chk("mid_rst_ferr", frame_err, 0);
        chk("mid_rst_tready", qin_tready, 0);
        exp_q.delete();
        out_idx = 0; beat_in_frame = 0; frame_cnt = 0;
        hold_pend = 0; bub_pend = 0; bub_end_pend = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        @(negedge clk);
        idle(6, 0);
        for (int n = 0; n < 4; n++)
            send((n == 0) ? mk(50, -50, 0, -1) : stim(n + 40), n == 3, 0,
                 n == 0, mk(38, -145, 0, -3));
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
